spi_txn_scheduler: RTL
======================

// Module: spi_txn_scheduler
// PURPOSE
//  Shares one SPI Master (start/spi_done/tx_data/rx_data/SCKdiv_val/SS) between NREQ requesters
//  (weight loader, feature-map loader, ...). Round-robin arbitrates bursts, drives per-slave chip
//  selects, sequences one master transaction per word, and returns rx words to the granted requester.
// PARAMETERS
//  NREQ     2   number of requesters (2..8)
//  DWIDTH   16  SPI word width; must equal the Master's DWIDTH
//  NCS      2   number of slave chip selects
//  CSW      1   width of a slave index, = clog2(NCS), min 1
//  LW       8   burst-length field width (words)
//  SETUP_CYC 2  clk cycles between cs_n/m_ss_n low and first m_start (>=1)
//  HOLD_CYC 2   clk cycles between last word captured and cs_n high (>=1)
//  GAP_CYC  2   clk cycles with all cs_n high before the next grant (>=1)
// PORTS
//  clk        in  1            system clock
//  nRst       in  1            asynchronous, active-low reset
//  req_valid  in  NREQ         burst request, level; held until grant[i]
//  req_cs     in  NREQ*CSW     slave index per requester, slice i = [i*CSW +: CSW]
//  req_len    in  NREQ*LW      burst word count per requester; 0 treated as 1
//  div_val    in  8            SCK divider, sampled at grant, held for whole burst
//  grant      out NREQ         one-hot, high from grant cycle until burst_done cycle inclusive
//  tx_valid   in  NREQ         tx word available from requester i
//  tx_data    in  NREQ*DWIDTH  tx word per requester, slice i = [i*DWIDTH +: DWIDTH]
//  tx_ready   out NREQ         1-cycle pulse: granted requester's tx word consumed
//  rx_data    out DWIDTH       last received word, held until next capture
//  rx_valid   out NREQ         1-cycle one-hot pulse when rx_data updated
//  burst_done out NREQ         1-cycle pulse coincident with final cs_n deassertion
//  busy       out 1            high whenever state != IDLE
//  cs_n       out NCS          active-low slave selects, at most one low
//  m_ss_n     out 1            to Master SS; low exactly when any cs_n is low
//  m_start    out 1            to Master start, 1-cycle pulse
//  m_tx_data  out DWIDTH       to Master tx_data, valid in m_start cycle
//  m_div_val  out 8            to Master SCKdiv_val, latched div_val
//  m_spi_done in  1            from Master spi_done
//  m_rx_data  in  DWIDTH       from Master rx_data
// BEHAVIOUR
//  Reset: cs_n all 1, m_ss_n 1, m_start 0, grant/tx_ready/rx_valid/burst_done 0, rx_data 0,
//   m_tx_data 0, m_div_val 0, busy 0, rr pointer NREQ-1 (requester 0 wins first), state IDLE.
//  Reset mid-burst: immediate abort, outputs to reset values; no burst_done issued.
//  FSM: IDLE->SETUP->LOAD->START->WAIT->CAPT->(LOAD | HOLD)->GAP->IDLE.
//  IDLE: if any req_valid, pick first set bit searching from pointer+1 (mod NREQ); assert grant,
//   latch cs index, len (0->1), div_val; pointer<=winner; drive cs_n[idx]=0, m_ss_n=0 -> SETUP.
//  SETUP: count SETUP_CYC cycles -> LOAD.
//  LOAD: wait tx_valid[g]; on it latch m_tx_data, pulse tx_ready[g] -> START. Stall indefinitely
//   with cs held low (no timeout).
//  START: m_start=1 one cycle -> WAIT. WAIT: on m_spi_done=1 -> CAPT.
//  CAPT: rx_data<=m_rx_data (one clk after done, Master rx final), pulse rx_valid[g], decrement
//   remaining; remaining>0 -> LOAD, else -> HOLD. Next m_start >=3 cycles after spi_done.
//  HOLD: HOLD_CYC cycles, then cs_n all 1, m_ss_n 1, burst_done[g], grant<=0 -> GAP.
//  GAP: GAP_CYC cycles -> IDLE; requests arriving earlier wait, none dropped.
//  req_valid/req_len/req_cs/div_val changes after grant ignored until next IDLE.
//  req_cs >= NCS: burst runs, m_ss_n low, all cs_n stay high.
//  m_spi_done outside WAIT ignored. Per-word latency, LOAD with tx_valid to rx_valid:
//   3 + Master transfer time (done cycle inclusive).
// STRUCTURE
//  Package spi_sched_pkg: state encoding localparams, clog2 function.
//  Sub-module spi_rr_arbiter (NREQ req, pointer in -> one-hot grant + index), combinational.
//  Top instantiates one Master alongside only in bench/system; the scheduler has no Master inside.
// TESTING (bench uses real Master, MISO looped to MOSI, div_val=2)
//  1 req0 len=1 cs=1 tx=16'hA5C3 -> cs_n=2'b01 during xfer, one m_start, rx_valid[0] with A5C3, burst_done[0].
//  2 req0,req1 high from reset, each len=1 -> grants 0,1,0,1; GAP_CYC all-high cs_n between.
//  3 req1 len=3, tx_valid 5-cycle gaps -> cs_n low continuously, 3 tx_ready, 3 rx_valid, 1 burst_done.
//  4 req_len=0 -> exactly one word transferred.
//  5 div_val 2->7 mid-burst -> m_div_val stays 2 until next grant, then 7.
//  6 nRst low during WAIT -> same cycle cs_n all 1, m_ss_n 1, grant 0; after release req0 served first.

Source files
------------

// File: rtl/spi_txn_scheduler_pkg.sv
// Shared types and helpers for the SPI transaction scheduler.
package spi_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_CAPT  = 3'd5,
    ST_HOLD  = 3'd6,
    ST_GAP   = 3'd7
  } state_t;

  // Width of the setup/hold/gap delay counter; cycle params stay below 256.
  localparam int CNT_W = 8;
  localparam int DIV_W = 8;

  // Ceiling log2, never less than 1 so single-entry indices still have a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/spi_txn_scheduler_if.sv
// Requester-side and SPI-Master-side bundle of the scheduler.
// slave: the scheduler's view; master: the system (requesters + Master) view.
interface spi_txn_scheduler_if #(
  parameter int NREQ   = 2,
  parameter int DWIDTH = 16,
  parameter int NCS    = 2,
  parameter int CSW    = 1,
  parameter int LW     = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*CSW-1:0]    req_cs;
  logic [NREQ*LW-1:0]     req_len;
  logic [7:0]             div_val;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        tx_valid;
  logic [NREQ*DWIDTH-1:0] tx_data;
  logic [NREQ-1:0]        tx_ready;
  logic [DWIDTH-1:0]      rx_data;
  logic [NREQ-1:0]        rx_valid;
  logic [NREQ-1:0]        burst_done;
  logic                   busy;
  logic [NCS-1:0]         cs_n;
  logic                   m_ss_n;
  logic                   m_start;
  logic [DWIDTH-1:0]      m_tx_data;
  logic [7:0]             m_div_val;
  logic                   m_spi_done;
  logic [DWIDTH-1:0]      m_rx_data;

  modport slave (
    input  req_valid, req_cs, req_len, div_val, tx_valid, tx_data, m_spi_done, m_rx_data,
    output grant, tx_ready, rx_data, rx_valid, burst_done, busy, cs_n, m_ss_n, m_start,
           m_tx_data, m_div_val
  );

  modport master (
    output req_valid, req_cs, req_len, div_val, tx_valid, tx_data, m_spi_done, m_rx_data,
    input  grant, tx_ready, rx_data, rx_valid, burst_done, busy, cs_n, m_ss_n, m_start,
           m_tx_data, m_div_val
  );
endinterface

// File: rtl/spi_txn_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after i_ptr (mod NREQ) wins.
module spi_rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = clog2(NREQ)
)(
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic            o_any,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx
);

  int w_dist;
  int w_best;

  // Pick the requesting index with the smallest rotated distance from i_ptr+1.
  always_comb begin
    o_any  = 1'b0;
    o_gnt  = '0;
    o_idx  = '0;
    w_best = NREQ;
    w_dist = 0;
    for (int j = 0; j < NREQ; j++) begin
      w_dist = (j + 2*NREQ - 1 - int'(i_ptr)) % NREQ;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_any    = 1'b1;
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one SPI Master between NREQ requesters: round-robin bursts, chip-select
// sequencing, one Master transaction per word, rx words routed to the grantee.
module spi_txn_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DWIDTH    = 16,
  parameter int NCS       = 2,
  parameter int CSW       = 1,
  parameter int LW        = 8,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 2
)(
  input logic clk,
  input logic nRst,
  spi_txn_scheduler_if.slave bus
);

  localparam int PW = clog2(NREQ);

  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic [NREQ-1:0]     r_grant;
  logic [NREQ-1:0]     r_tx_ready;
  logic [NREQ-1:0]     r_rx_valid;
  logic [NREQ-1:0]     r_burst_done;
  logic [LW-1:0]       r_rem;
  logic [CNT_W-1:0]    r_cnt;
  logic [NCS-1:0]      r_cs_n;
  logic                r_ss_n;
  logic                r_start;
  logic [DWIDTH-1:0]   r_tx;
  logic [DWIDTH-1:0]   r_rx;
  logic [DIV_W-1:0]    r_div;

  logic                w_any;
  logic [NREQ-1:0]     w_gnt;
  logic [PW-1:0]       w_idx;
  logic [CSW-1:0]      w_req_cs;
  logic [LW-1:0]       w_req_len;
  logic [DWIDTH-1:0]   w_tx_word;
  logic [NCS-1:0]      w_cs_dec;
  logic                w_tx_ok;

  spi_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  // Select the arbitration winner's cs/len and the current grantee's tx word.
  always_comb begin
    w_req_cs  = '0;
    w_req_len = '0;
    w_tx_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_req_cs  = bus.req_cs[i*CSW +: CSW];
        w_req_len = bus.req_len[i*LW +: LW];
      end
      if (r_grant[i]) w_tx_word = bus.tx_data[i*DWIDTH +: DWIDTH];
    end
  end

  // Active-low decode of the winner's slave index; out-of-range keeps every cs_n high.
  always_comb begin
    w_cs_dec = '1;
    for (int j = 0; j < NCS; j++) w_cs_dec[j] = (int'(w_req_cs) != j);
  end

  assign w_tx_ok = |(bus.tx_valid & r_grant);

  // Burst sequencer; every output is a register so the Master sees clean levels.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= PW'(NREQ-1);
      r_grant      <= '0;
      r_tx_ready   <= '0;
      r_rx_valid   <= '0;
      r_burst_done <= '0;
      r_rem        <= '0;
      r_cnt        <= '0;
      r_cs_n       <= '1;
      r_ss_n       <= 1'b1;
      r_start      <= 1'b0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_div        <= '0;
    end else begin
      r_start      <= 1'b0;
      r_tx_ready   <= '0;
      r_rx_valid   <= '0;
      r_burst_done <= '0;
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_grant <= w_gnt;
          r_ptr   <= w_idx;
          r_rem   <= (w_req_len == '0) ? LW'(1) : w_req_len;
          r_div   <= bus.div_val;
          r_cs_n  <= w_cs_dec;
          r_ss_n  <= 1'b0;
          r_cnt   <= CNT_W'(SETUP_CYC-1);
          r_state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (r_cnt == '0) r_state <= ST_LOAD;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        // No timeout: a slow requester simply keeps its slave selected.
        ST_LOAD: if (w_tx_ok) begin
          r_tx       <= w_tx_word;
          r_tx_ready <= r_grant;
          r_start    <= 1'b1;
          r_state    <= ST_START;
        end
        ST_START: r_state <= ST_WAIT;
        ST_WAIT:  if (bus.m_spi_done) r_state <= ST_CAPT;
        // Master rx word is final one clk after spi_done, hence capture here.
        ST_CAPT: begin
          r_rx       <= bus.m_rx_data;
          r_rx_valid <= r_grant;
          r_rem      <= r_rem - LW'(1);
          if (r_rem == LW'(1)) begin
            r_cnt   <= CNT_W'(HOLD_CYC-1);
            r_state <= ST_HOLD;
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_cs_n       <= '1;
            r_ss_n       <= 1'b1;
            r_burst_done <= r_grant;
            r_cnt        <= CNT_W'(GAP_CYC-1);
            r_state      <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        // Grant is dropped one cycle late so it covers the burst_done cycle.
        ST_GAP: begin
          r_grant <= '0;
          if (r_cnt == '0) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant      = r_grant;
  assign bus.tx_ready   = r_tx_ready;
  assign bus.rx_data    = r_rx;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.burst_done = r_burst_done;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.cs_n       = r_cs_n;
  assign bus.m_ss_n     = r_ss_n;
  assign bus.m_start    = r_start;
  assign bus.m_tx_data  = r_tx;
  assign bus.m_div_val  = r_div;

endmodule
